display_sched: RTL
==================

# display_sched

Top-level display scheduler for the 7-digit multiplexed seven-segment panel. In RUN it scans the seven stored character codes onto the panel and scrolls them one position per scroll period. In EDIT it hands the panel to the `setting` block and drives that block's `mode` input. It owns the mode state machine, the pause control and the shared digit-scan timing.

## Interface
- `SCAN_DIV`, default 25000: clk cycles per digit slot (terminal count; the slot lasts `SCAN_DIV`+1 cycles).
- `SCROLL_DIV`, default 12500000: clk cycles per scroll step (terminal count).
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-low.
- `mode_btn` in 1: debounced single-cycle pulse; toggles RUN/PAUSE ↔ EDIT.
- `pause_btn` in 1: debounced single-cycle pulse; toggles RUN ↔ PAUSE.
- `char_code` in 49: seven 7-bit character indices; bits [7k+6:7k] are digit k.
- `edit_trans` in 7: digit enables from the `setting` block, active-low.
- `edit_seg` in 7: segment pattern from the `setting` block, active-low.
- `edit_mode` out 1: drives `setting.mode`; 1 only in EDIT.
- `trans` out 7: panel digit enables, active-low, one-hot-zero; bit 6 is digit 0.
- `led7seg` out 7: panel segments, active-low.
- `offset` out 3: current scroll offset, 0..6.

## Operation
- FSM states: RUN, PAUSE, EDIT. The reset state is RUN.
- RUN, `mode_btn` → EDIT.
- RUN, `pause_btn` → PAUSE.
- PAUSE, `pause_btn` → RUN.
- PAUSE, `mode_btn` → EDIT.
- EDIT, `mode_btn` → RUN, with `offset` cleared to 0 and the scroll counter cleared.
- EDIT, `pause_btn` is ignored.
- If both pulses arrive in the same cycle, `mode_btn` wins and `pause_btn` is dropped.
- Scan counter:
  - counts 0..`SCAN_DIV` in every state;
  - on wrap, `digit` advances 0→6 and then wraps to 0.
- Scroll counter:
  - counts 0..`SCROLL_DIV` only in RUN and holds its value in PAUSE;
  - on wrap, `offset` = (`offset`+1) mod 7, so 6 wraps to 0.
- RUN/PAUSE panel output: digit d shows `char_code` slot (d+`offset`) mod 7, decoded through `table_char`. `trans` bit (6−d) is 0 and all other bits are 1.
- EDIT panel output: `trans`/`led7seg` = `edit_trans`/`edit_seg`, registered once.
- Anti-ghost blanking: in RUN/PAUSE, `trans` = 7'h7F for the first cycle of every digit slot.
- `edit_mode` is a registered decode of the state.

## Timing
- Reset values:
  - `trans` = 7'h7F, `led7seg` = 7'h7F, `edit_mode` = 0, `offset` = 0;
  - digit = 0, both counters = 0, state = RUN.
- All outputs are registered; there is no combinational input→output path.
- `table_char` has one cycle of registered latency. The digit-select path for `trans` is delayed one cycle so that segments and enable change on the same clk edge.
- In RUN, the first valid digit-0 enable appears at cycle 2 after `rst` deasserts: cycle 1 is the blank cycle and cycle 2 is the first cycle with aligned data.
- EDIT pass-through latency is 1 cycle from `edit_*` to `trans`/`led7seg`.
- State change takes effect on the edge that samples the pulse. `edit_mode` changes 1 cycle later.
- `offset` changes only at a slot boundary (`digit`==6 wrap) if a scroll wrap is pending. A pending step is held until that boundary, so a frame never mixes two offsets.
- `rst` asserted mid-operation: every register returns to its reset value asynchronously, and the panel blanks immediately.
- `char_code` is sampled when the slot's decoder is loaded. Changes mid-slot appear at the next slot.

## Structure
- Shared package: `NUM_DIGITS`=7, `LED_NULL`=7'h7F, and the state enum {RUN, PAUSE, EDIT}. `setting` consumes the same package.
- One sub-module: a single `table_char` instance fed by the 7-bit code selected by the 49-bit mux.
- Counter, FSM and output-register logic stay flat in `display_sched`.

## Test plan
- Reset release, `SCAN_DIV`=3, `SCROLL_DIV`=100, `char_code` slot k=k+10:
  - `trans` cycles 7'h3F, 7'h5F, …, 7'h7E;
  - each enable follows one 7'h7F blank cycle;
  - `led7seg` = decode(10+k).
- Hold in RUN past the first scroll wrap:
  - `offset` becomes 1 exactly at the next digit-6→0 boundary;
  - digit 0 shows code 11 and digit 6 shows code 10.
- Run 7 scroll steps → `offset` wraps 6→0.
- `pause_btn` in RUN:
  - `offset` frozen for 3×`SCROLL_DIV` cycles while scanning continues;
  - second `pause_btn` resumes from the held count.
- `mode_btn` in RUN:
  - `edit_mode`=1 after 1 cycle;
  - `edit_trans`=7'h5F, `edit_seg`=7'h12 appear 1 cycle later;
  - `pause_btn` is ignored;
  - `mode_btn` again → RUN with `offset`=0.
- `mode_btn` and `pause_btn` pulsed in the same cycle from RUN → EDIT.
- `rst` low mid-slot → outputs 7'h7F with no clk edge; RUN restarts from digit 0.

Source files
------------

// File: rtl/display_sched_pkg.sv
// Shared definitions for the seven-digit display scheduler and the setting block.
// Holds panel geometry, the blank pattern, the mode enum and small index helpers.
package display_sched_pkg;

   localparam int         NUM_DIGITS = 7;
   localparam logic [6:0] LED_NULL   = 7'h7F;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PAUSE = 2'd1,
      EDIT  = 2'd2
   } state_e;

   // Active-low enable for one digit; digit 0 lives on bit 6.
   function automatic logic [6:0] digit_enable_n(input logic [2:0] digit);
      digit_enable_n = ~(7'b100_0000 >> digit);
   endfunction

   function automatic logic [2:0] slot_index(input logic [2:0] digit, input logic [2:0] offset);
      logic [3:0] sum;
      sum = {1'b0, digit} + {1'b0, offset};
      if (sum >= 4'd7) begin
         sum = sum - 4'd7;
      end
      slot_index = sum[2:0];
   endfunction

endpackage

// File: rtl/display_sched_if.sv
// Panel-side bus of the display scheduler: character codes, setting pass-through and panel drive.
interface display_sched_if;
   import display_sched_pkg::*;

   logic [7*NUM_DIGITS-1:0] char_code;
   logic [6:0]              edit_trans;
   logic [6:0]              edit_seg;
   logic                    edit_mode;
   logic [6:0]              trans;
   logic [6:0]              led7seg;
   logic [2:0]              offset;

   modport master (
      output char_code, edit_trans, edit_seg,
      input  edit_mode, trans, led7seg, offset
   );

   modport slave (
      input  char_code, edit_trans, edit_seg,
      output edit_mode, trans, led7seg, offset
   );

endinterface

// File: rtl/display_sched_table_char.sv
// Character-code to active-low segment decoder with a registered, load-enabled output.
// Codes 0-15 are hex glyphs; every other code renders as a dash.
module table_char
   import display_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [6:0] code,
   output logic [6:0] seg
);

   logic [6:0] seg_q;
   logic [6:0] seg_d;
   logic [6:0] pattern;

   always_comb begin
      case (code)
         7'd0:    pattern = 7'h40;
         7'd1:    pattern = 7'h79;
         7'd2:    pattern = 7'h24;
         7'd3:    pattern = 7'h30;
         7'd4:    pattern = 7'h19;
         7'd5:    pattern = 7'h12;
         7'd6:    pattern = 7'h02;
         7'd7:    pattern = 7'h78;
         7'd8:    pattern = 7'h00;
         7'd9:    pattern = 7'h10;
         7'd10:   pattern = 7'h08;
         7'd11:   pattern = 7'h03;
         7'd12:   pattern = 7'h46;
         7'd13:   pattern = 7'h21;
         7'd14:   pattern = 7'h06;
         7'd15:   pattern = 7'h0E;
         default: pattern = 7'h3F;
      endcase
   end

   // Only reload at the start of a slot so a digit never changes glyph mid-slot.
   always_comb begin
      seg_d = seg_q;
      if (load) begin
         seg_d = pattern;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_q <= LED_NULL;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;

endmodule

// File: rtl/display_sched.sv
// Display scheduler top: mode FSM, pause control, digit-scan and scroll timing,
// and the registered panel drive shared between RUN/PAUSE scanning and EDIT pass-through.
module display_sched
   import display_sched_pkg::*;
#(
   parameter int SCAN_DIV   = 25000,
   parameter int SCROLL_DIV = 12500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_btn,
   input  logic             pause_btn,
   display_sched_if.slave   bus
);

   localparam int SCAN_W   = (SCAN_DIV > 0)   ? $clog2(SCAN_DIV + 1)   : 1;
   localparam int SCROLL_W = (SCROLL_DIV > 0) ? $clog2(SCROLL_DIV + 1) : 1;

   state_e              state_q, state_d;
   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic [2:0]          digit_q, digit_d;
   logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
   logic [2:0]          offset_q, offset_d;
   logic                pend_q, pend_d;
   logic                edit_mode_q, edit_mode_d;
   logic [6:0]          trans_q, trans_d;
   logic [6:0]          edit_seg_q, edit_seg_d;

   logic                scroll_en;
   logic                scroll_clr;
   logic                scan_wrap;
   logic                frame_wrap;
   logic                scroll_wrap;
   logic                slot_load;
   logic [5:0]          slot_base;
   logic [6:0]          slot_code;
   logic [6:0]          tbl_seg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // A mode pulse always wins over a simultaneous pause pulse.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (mode_btn)       state_d = EDIT;
            else if (pause_btn) state_d = PAUSE;
         end
         PAUSE: begin
            if (mode_btn)       state_d = EDIT;
            else if (pause_btn) state_d = RUN;
         end
         EDIT: begin
            if (mode_btn)       state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      scroll_en   = (state_q == RUN);
      scroll_clr  = (state_q == EDIT) && mode_btn;
      edit_mode_d = (state_q == EDIT);
   end

   // A scroll step is parked until the frame ends so one frame never mixes offsets.
   always_comb begin
      scan_wrap    = (scan_cnt_q == SCAN_W'(SCAN_DIV));
      frame_wrap   = scan_wrap && (digit_q == 3'(NUM_DIGITS - 1));
      scroll_wrap  = scroll_en && (scroll_cnt_q == SCROLL_W'(SCROLL_DIV));

      scan_cnt_d   = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
      digit_d      = digit_q;
      if (scan_wrap) begin
         digit_d = frame_wrap ? 3'd0 : digit_q + 3'd1;
      end

      scroll_cnt_d = scroll_cnt_q;
      if (scroll_en) begin
         scroll_cnt_d = scroll_wrap ? '0 : scroll_cnt_q + SCROLL_W'(1);
      end

      offset_d = offset_q;
      pend_d   = pend_q | scroll_wrap;
      if (frame_wrap && pend_d) begin
         offset_d = (offset_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : offset_q + 3'd1;
         pend_d   = 1'b0;
      end

      if (scroll_clr) begin
         scroll_cnt_d = '0;
         offset_d     = 3'd0;
         pend_d       = 1'b0;
      end
   end

   always_comb begin
      slot_load  = (scan_cnt_q == '0);
      slot_base  = 6'(slot_index(digit_q, offset_q)) * 6'd7;
      slot_code  = bus.char_code[slot_base +: 7];
      edit_seg_d = bus.edit_seg;
      if (state_q == EDIT) begin
         trans_d = bus.edit_trans;
      end else if (slot_load) begin
         trans_d = LED_NULL;
      end else begin
         trans_d = digit_enable_n(digit_q);
      end
   end

   table_char u_table_char (
      .clk  (clk),
      .rst  (rst),
      .load (slot_load),
      .code (slot_code),
      .seg  (tbl_seg)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt_q   <= '0;
         digit_q      <= 3'd0;
         scroll_cnt_q <= '0;
         offset_q     <= 3'd0;
         pend_q       <= 1'b0;
         edit_mode_q  <= 1'b0;
         trans_q      <= LED_NULL;
         edit_seg_q   <= LED_NULL;
      end else begin
         scan_cnt_q   <= scan_cnt_d;
         digit_q      <= digit_d;
         scroll_cnt_q <= scroll_cnt_d;
         offset_q     <= offset_d;
         pend_q       <= pend_d;
         edit_mode_q  <= edit_mode_d;
         trans_q      <= trans_d;
         edit_seg_q   <= edit_seg_d;
      end
   end

   // Both segment sources are registers and the select is registered, so outputs stay flop-driven.
   assign bus.trans     = trans_q;
   assign bus.led7seg   = edit_mode_q ? edit_seg_q : tbl_seg;
   assign bus.edit_mode = edit_mode_q;
   assign bus.offset    = offset_q;

endmodule
